multitone_stim_gen: RTL
=======================

Name: multitone_stim_gen

Overview:
- Synthesizable N-tone stimulus generator for FIR filter bring-up on hardware.
- Runs one phase accumulator per tone in the CORDIC phase format (Q3.13 radians, wrap at ±pi) and streams the phase vector to CORDIC sin/cos cores.
- Takes the returned sines, averages them, and decimates to the FIR sample rate.
- Output drives the filter's inData/enable directly.

Parameters:
- NUM_TONES, 2, number of tones/accumulators (power of two, 1..8).
- PHASE_W, 16, phase word width; PI_POS = round(pi·2^(PHASE_W-3)) (0x6488 at 16), PI_NEG = -PI_POS (0x9B78).
- DATA_W, 16, sine sample and output width, signed.
- DECIM, 5, accepted sine beats per output sample (1..255).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run/hold.
- cfg_wr  in  1  phase-increment write strobe.
- cfg_sel  in  clog2(NUM_TONES) (min 1)  tone index for the write.
- cfg_inc  in  PHASE_W  unsigned phase increment.
- cfg_err  out  1  sticky flag: illegal increment rejected.
- m_phase_tvalid  out  1  phase vector valid.
- m_phase_tready  in  1  CORDIC ready (tie high if the core has none).
- m_phase_tdata  out  NUM_TONES*PHASE_W  tone k at bits [k*PHASE_W +: PHASE_W].
- s_sin_tvalid  in  1  sine vector valid.
- s_sin_tdata  in  NUM_TONES*DATA_W  same packing as m_phase_tdata.
- out_valid  out  1  one-cycle strobe per output sample.
- out_data  out  DATA_W  mixed, decimated sample.

Behaviour:
- Reset (async assert, sync release) clears:
  - all accumulators, increments, cfg_err, m_phase_tvalid, out_valid, out_data (0);
  - the decimation counter and the sum register.
- m_phase_tvalid is a register of enable: it rises 1 cycle after enable is sampled high and falls 1 cycle after enable is sampled low.
- Accumulators advance only on m_phase_tvalid & m_phase_tready. While stalled, tdata stays stable.
- Per-tone update, computed at PHASE_W+1 bits, with s = acc + inc:
  - if s < PI_POS, acc <= s;
  - else acc <= PI_NEG + (s - PI_POS).
  - Equality (s == PI_POS) wraps to exactly PI_NEG.
- Increments:
  - A cfg_wr with cfg_inc < PI_POS loads inc[cfg_sel] and takes effect from the next handshake.
  - A write with cfg_inc ≥ PI_POS, or cfg_sel ≥ NUM_TONES, is ignored and sets cfg_err; only reset clears cfg_err.
  - A write coincident with a handshake: that update uses the old increment.
- Mixer, stage 1, on s_sin_tvalid: sum = Σ sign-extended sines at DATA_W+log2(NUM_TONES) bits.
- Mixer, stage 2: out = sum / NUM_TONES, truncated toward zero. Implemented as an arithmetic shift after adding NUM_TONES-1 when sum is negative. This is bit-exact to the behavioural model's signed divide.
- Decimation:
  - The counter counts accepted s_sin_tvalid beats 0..DECIM-1.
  - On the beat where count == DECIM-1, stage 2 registers out_data and pulses out_valid.
  - Latency is 2 clk from that s_sin_tvalid to out_valid.
  - The first output comes from beat DECIM after reset.
  - DECIM=1 gives every beat.
- out_data holds between strobes.
- enable low: sine beats are still mixed, but the decimation counter holds and no out_valid is produced. The pipeline drains: a strobe already in stage 2 still emits.
- Reset mid-stream discards in-flight sums; nothing is emitted from pre-reset beats.

Optional Feature:
- Macro: MULTITONE_STIM_DITHER_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 0xACE1 at reset) advances once per out_valid.
  - Its bits [3:0], read as signed 4-bit, are added to the stage-2 result before registering.
  - The result saturates to the DATA_W range (0x7FFF/0x8000 at 16).
- Undefined: no LFSR and no dither adder; out_data is bit-exact to the undithered mix.

Test Plan:
- Reset, enable=1, inc = {200, 3000} → m_phase_tvalid high 1 cycle after enable; after 1 handshake tdata = {200, 3000}; after 2 → {400, 6000}.
- Tone-1 accumulator at 0x6400, inc 3000 → next value -22872 (0xA6A8). Force s == 0x6488 → value 0x9B78.
- m_phase_tready low for 4 cycles mid-run → tdata frozen, no accumulator step; resumes with the correct next value.
- s_sin_tdata {0x4000, 0x2000}, DECIM=1 → out_data 12288 after 2 clk. {-3, 0} → -1. {0x8000, 0x8000} → 0x8000.
- DECIM=5, 12 continuous beats → out_valid on beats 5 and 10 only (+2 clk). cfg_inc=0x7000 → ignored, cfg_err=1.
- Reset pulse asserted between beats 3 and 4 → all outputs 0 immediately; the next out_valid comes 5 beats after release. With the macro defined: output differs from the mix by at most [-8, 7] and saturates at full scale.

Source files
------------

// File: rtl/multitone_stim_gen.sv
// N-tone stimulus generator: per-tone Q3.13 phase accumulators feeding CORDIC, sine mixer and decimator.
// Optional output dither is built in when MULTITONE_STIM_DITHER_EN is defined.
module multitone_stim_gen #(
    parameter int NUM_TONES = 2,
    parameter int PHASE_W   = 16,
    parameter int DATA_W    = 16,
    parameter int DECIM     = 5,
    localparam int SEL_W    = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          cfg_wr,
    input  logic [SEL_W-1:0]              cfg_sel,
    input  logic [PHASE_W-1:0]            cfg_inc,
    output logic                          cfg_err,
    output logic                          m_phase_tvalid,
    input  logic                          m_phase_tready,
    output logic [NUM_TONES*PHASE_W-1:0]  m_phase_tdata,
    input  logic                          s_sin_tvalid,
    input  logic [NUM_TONES*DATA_W-1:0]   s_sin_tdata,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data
);

    localparam int LOG2     = $clog2(NUM_TONES);
    localparam int SUM_W    = DATA_W + LOG2;
    localparam int PI_POS_I = $rtoi(3.14159265358979 * (2.0 ** (PHASE_W - 3)) + 0.5);

    localparam logic [PHASE_W-1:0]        PI_POS   = PHASE_W'(PI_POS_I);
    localparam logic [PHASE_W-1:0]        TWO_PI   = PHASE_W'(2 * PI_POS_I);
    localparam logic signed [PHASE_W:0]   PI_POS_X = (PHASE_W + 1)'(PI_POS_I);
    localparam logic [SEL_W:0]            NT_X     = (SEL_W + 1)'(NUM_TONES);
    localparam logic [7:0]                DECIM_M1 = 8'(DECIM - 1);

    logic                       r_phase_tvalid;
    logic [PHASE_W-1:0]         r_acc [NUM_TONES];
    logic [PHASE_W-1:0]         r_inc [NUM_TONES];
    logic                       r_cfg_err;
    logic [7:0]                 r_cnt;
    logic signed [SUM_W-1:0]    r_sum;
    logic                       r_s1_last;
    logic                       r_out_valid;
    logic [DATA_W-1:0]          r_out_data;

    logic                       w_hs;
    logic signed [PHASE_W:0]    w_ph_sum  [NUM_TONES];
    logic [PHASE_W-1:0]         w_acc_nxt [NUM_TONES];
    logic signed [SUM_W-1:0]    w_sum;
    logic signed [SUM_W-1:0]    w_adj;
    logic signed [DATA_W-1:0]   w_mix;
    logic [DATA_W-1:0]          w_out;

    assign w_hs = r_phase_tvalid & m_phase_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_tvalid <= 1'b0;
        end else begin
            r_phase_tvalid <= enable;
        end
    end

    // Sum at PHASE_W+1 bits; once past +pi, subtracting 2*pi modulo 2^PHASE_W lands on PI_NEG + (s - PI_POS).
    always_comb begin
        for (int k = 0; k < NUM_TONES; k++) begin
            w_ph_sum[k]  = $signed({r_acc[k][PHASE_W-1], r_acc[k]}) + $signed({1'b0, r_inc[k]});
            w_acc_nxt[k] = (w_ph_sum[k] < PI_POS_X) ? w_ph_sum[k][PHASE_W-1:0]
                                                    : w_ph_sum[k][PHASE_W-1:0] - TWO_PI;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TONES; k++) begin
                r_acc[k] <= '0;
            end
        end else if (w_hs) begin
            for (int k = 0; k < NUM_TONES; k++) begin
                r_acc[k] <= w_acc_nxt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TONES; k++) begin
                r_inc[k] <= '0;
            end
            r_cfg_err <= 1'b0;
        end else if (cfg_wr) begin
            if ((cfg_inc >= PI_POS) || ({1'b0, cfg_sel} >= NT_X)) begin
                r_cfg_err <= 1'b1;
            end else begin
                r_inc[cfg_sel] <= cfg_inc;
            end
        end
    end

    for (genvar k = 0; k < NUM_TONES; k++) begin : g_pack
        assign m_phase_tdata[k*PHASE_W +: PHASE_W] = r_acc[k];
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_TONES; k++) begin
            w_sum = w_sum + SUM_W'($signed(s_sin_tdata[k*DATA_W +: DATA_W]));
        end
    end

    // Bias negatives by N-1 so the arithmetic shift truncates toward zero like a signed divide.
    assign w_adj = r_sum[SUM_W-1] ? (r_sum + SUM_W'(NUM_TONES - 1)) : r_sum;
    assign w_mix = DATA_W'(w_adj >>> LOG2);

`ifdef MULTITONE_STIM_DITHER_EN
    logic [15:0]              r_lfsr;
    logic signed [DATA_W:0]   w_dith;

    always_comb begin
        w_dith = (DATA_W + 1)'(w_mix) + (DATA_W + 1)'($signed(r_lfsr[3:0]));
        if (w_dith[DATA_W] != w_dith[DATA_W-1]) begin
            w_out = w_dith[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            w_out = w_dith[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else if (r_s1_last) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end
`else
    assign w_out = w_mix;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_s1_last <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (s_sin_tvalid) begin
                r_sum <= w_sum;
            end
            r_s1_last <= s_sin_tvalid & enable & (r_cnt == DECIM_M1);
            if (s_sin_tvalid & enable) begin
                r_cnt <= (r_cnt == DECIM_M1) ? 8'd0 : r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_s1_last;
            if (r_s1_last) begin
                r_out_data <= w_out;
            end
        end
    end

    assign cfg_err        = r_cfg_err;
    assign m_phase_tvalid = r_phase_tvalid;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;

endmodule
